inst_fetch_unit: RTL and testbench

- Producer side of the instruction stream that feeds the top-level controller.
- On a start command, reads a run of INST_LEN-bit instructions from the on-chip instruction RAM (synchronous read, 1-cycle latency).
- Buffers them in a first-word-fall-through queue and presents them on instruct/inst_empty.
- The controller consumes one instruction per single-cycle inst_req pulse.

---
 rtl/inst_fetch_unit_pkg.sv | 16 +
 rtl/inst_fwft_fifo.sv | 40 ++++
 rtl/inst_fetch_unit.sv | 75 +++++++
 tb/tb_inst_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared widths and instruction-type encoding for the fetch path
package inst_fetch_unit_pkg;
  localparam int INST_LEN = 220;
  localparam int IMEM_AW = 12;
  localparam int CNT_LEN = 16;
  localparam int QDEPTH_LOG2 = 3;
  localparam int INST_TYPE_LSB = 0;
  localparam int INST_TYPE_MSB = 3;
  typedef enum logic [3:0] {
    INST_COMPUTE     = 4'd0,
    INST_LOAD_WEIGHT = 4'd1,
    INST_LOAD_BIAS   = 4'd2,
    INST_LOAD_DATA   = 4'd3,
    INST_WRITE_DATA  = 4'd4
  } inst_type_e;
endpackage

// File: rtl/inst_fwft_fifo.sv
// inst_fwft_fifo: first-word-fall-through queue with occupancy and sticky underflow flag
module inst_fwft_fifo import inst_fetch_unit_pkg::*; #(
  parameter int W = INST_LEN,
  parameter int AW = QDEPTH_LOG2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [AW:0]   occupancy,
  output logic          underflow
);
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign empty = occupancy == '0;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  // storage, pointers and occupancy; storage is cleared so the head reads zero after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      occupancy <= occupancy + (AW+1)'(push) - (AW+1)'(do_pop);
      underflow <= underflow | (pop && empty);
    end
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetches a run of instructions from RAM into an FWFT queue for the controller
module inst_fetch_unit import inst_fetch_unit_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IMEM_AW-1:0]  start_addr,
  input  logic [CNT_LEN-1:0]  inst_count,
  output logic                busy,
  output logic                done,
  output logic                imem_rd_en,
  output logic [IMEM_AW-1:0]  imem_rd_addr,
  input  logic [INST_LEN-1:0] imem_rd_data,
  output logic [INST_LEN-1:0] instruct,
  output logic                inst_empty,
  input  logic                inst_req,
  output logic                underflow
);
  localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
  localparam int QDEPTH = 2**QDEPTH_LOG2;
  logic [1:0] state;
  logic [IMEM_AW-1:0] next_addr;
  logic [CNT_LEN-1:0] remaining;
  logic inflight, issue, pop, drain_done;
  logic [QDEPTH_LOG2:0] occupancy;
  logic [QDEPTH_LOG2+1:0] credit_used;
  assign credit_used = {1'b0, occupancy} + (QDEPTH_LOG2+2)'(inflight);
  assign issue = state == S_FETCH && remaining != '0 && credit_used < (QDEPTH_LOG2+2)'(QDEPTH);
  assign imem_rd_en = issue;
  assign imem_rd_addr = next_addr;
  assign pop = inst_req && !inst_empty;
  assign drain_done = !inflight && (inst_empty || (occupancy == (QDEPTH_LOG2+1)'(1) && pop));
  // fetch sequencing: accept start, issue credited reads, then wait for the queue to drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      next_addr <= '0;
      remaining <= '0;
      inflight <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      inflight <= issue;
      done <= state == S_DONE;
      if (issue) begin
        next_addr <= next_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      case (state)
        S_IDLE: if (start) begin
          busy <= 1'b1;
          next_addr <= start_addr;
          remaining <= inst_count;
          state <= inst_count == '0 ? S_DONE : S_FETCH;
        end
        S_FETCH: if (issue && remaining == CNT_LEN'(1)) state <= S_DRAIN;
        S_DRAIN: if (drain_done) state <= S_DONE;
        default: begin
          busy <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
  inst_fwft_fifo #(.W(INST_LEN), .AW(QDEPTH_LOG2)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(inflight),
    .din(imem_rd_data),
    .pop(inst_req),
    .dout(instruct),
    .empty(inst_empty),
    .occupancy(occupancy),
    .underflow(underflow)
  );
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed scenario tests for the instruction fetch unit
module tb_inst_fetch_unit;
  localparam int W = 220;
  localparam int AW = 12;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [CW-1:0] inst_count = '0;
  logic busy, done, imem_rd_en, inst_empty, underflow;
  logic [AW-1:0] imem_rd_addr;
  logic [W-1:0] imem_rd_data = '0;
  logic [W-1:0] instruct;
  logic inst_req = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc_n, done_cnt, done_at;
  logic [AW-1:0] rd_q[$];
  logic [W-1:0] got_q[$];
  int pop_at[$];

  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .inst_count(inst_count),
    .busy(busy), .done(done), .imem_rd_en(imem_rd_en), .imem_rd_addr(imem_rd_addr),
    .imem_rd_data(imem_rd_data), .instruct(instruct), .inst_empty(inst_empty),
    .inst_req(inst_req), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // RAM model: RAM[i] = i, one-cycle synchronous read
  always @(posedge clk) if (imem_rd_en) imem_rd_data <= W'(imem_rd_addr);

  task automatic cyc(input bit pop_en);
    @(negedge clk);
    start = 1'b0;
    cyc_n++;
    if (imem_rd_en) rd_q.push_back(imem_rd_addr);
    if (done) begin
      done_cnt++;
      done_at = cyc_n;
    end
    inst_req = pop_en && !inst_empty;
    if (inst_req) begin
      got_q.push_back(instruct);
      pop_at.push_back(cyc_n);
    end
  endtask

  task automatic go(input logic [AW-1:0] a, input logic [CW-1:0] n);
    rd_q.delete();
    got_q.delete();
    pop_at.delete();
    cyc_n = 0;
    done_cnt = 0;
    done_at = 0;
    start_addr = a;
    inst_count = n;
    start = 1'b1;
  endtask

  task automatic run(input bit pop_en, input int max);
    for (int i = 0; i < max && done_cnt == 0; i++) cyc(pop_en);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 7;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", imem_rd_en); end
    if (imem_rd_addr !== '0) begin failures++; $display("FAIL reset_rd_addr got=%h exp=0", imem_rd_addr); end
    if (inst_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", inst_empty); end
    if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    if (instruct !== '0) begin failures++; $display("FAIL reset_instruct got=%h exp=0", instruct); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int bad;
    int exp_at;
    bad = 0;
    go(12'h010, 16'd3);
    run(1'b1, 40);
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    checks++;
    if (got_q.size() != 3) begin failures++; $display("FAIL basic_pop_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== W'(16 + i)) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL basic_order mismatches=%0d exp=0", bad); end
    exp_at = pop_at.size() == 3 ? pop_at[2] + 2 : -1;
    checks++;
    if (done_at != exp_at) begin failures++; $display("FAIL basic_done_timing got=%0d exp=%0d", done_at, exp_at); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    cyc(1'b0);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++;
    if (underflow !== 1'b0) begin failures++; $display("FAIL basic_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    go(12'h100, 16'd20);
    repeat (50) cyc(1'b0);
    checks++;
    if (rd_q.size() != 8) begin failures++; $display("FAIL bp_reads_held got=%0d exp=8", rd_q.size()); end
    checks++;
    if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL bp_rd_en_stalled got=%b exp=0", imem_rd_en); end
    checks++;
    if (instruct !== W'(12'h100)) begin failures++; $display("FAIL bp_head got=%h exp=100", instruct); end
    run(1'b1, 120);
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
    checks++;
    if (got_q.size() != 20) begin failures++; $display("FAIL bp_pop_count got=%0d exp=20", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== W'(12'h100 + i)) bad++;
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] !== AW'(12'h100 + i)) bad++;
    checks++;
    if (bad != 0 || rd_q.size() != 20) begin failures++; $display("FAIL bp_order mismatches=%0d reads=%0d exp=0/20", bad, rd_q.size()); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4];
    int bad;
    bad = 0;
    exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    go(12'hFFE, 16'd4);
    run(1'b1, 40);
    checks++;
    if (rd_q.size() != 4) begin failures++; $display("FAIL wrap_read_count got=%0d exp=4", rd_q.size()); end
    for (int i = 0; i < rd_q.size() && i < 4; i++) if (rd_q[i] !== exp_a[i]) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL wrap_addr mismatches=%0d exp=0", bad); end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < 4; i++) if (got_q[i] !== W'(exp_a[i])) bad++;
    checks++;
    if (bad != 0 || got_q.size() != 4) begin failures++; $display("FAIL wrap_data mismatches=%0d pops=%0d exp=0/4", bad, got_q.size()); end
  endtask

  task automatic test_zero_and_busy();
    int bad;
    bad = 0;
    go(12'h020, 16'd0);
    cyc(1'b1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL zero_first busy=%b done=%b exp=1/0", busy, done); end
    cyc(1'b1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL zero_done done=%b busy=%b exp=1/0", done, busy); end
    cyc(1'b1);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
    checks++;
    if (rd_q.size() != 0) begin failures++; $display("FAIL zero_no_reads got=%0d exp=0", rd_q.size()); end
    go(12'h030, 16'd5);
    repeat (3) cyc(1'b1);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_mid_run got=%b exp=1", busy); end
    start_addr = 12'h200;
    inst_count = 16'd2;
    start = 1'b1;
    run(1'b1, 40);
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== W'(12'h030 + i)) bad++;
    checks++;
    if (bad != 0 || got_q.size() != 5) begin failures++; $display("FAIL restart_ignored mismatches=%0d pops=%0d exp=0/5", bad, got_q.size()); end
    checks++;
    if (rd_q.size() != 5 || done_cnt != 1) begin failures++; $display("FAIL restart_reads got=%0d done=%0d exp=5/1", rd_q.size(), done_cnt); end
  endtask

  task automatic test_underflow_throughput();
    int bad;
    int span;
    bad = 0;
    inst_req = 1'b1;
    @(negedge clk);
    inst_req = 1'b0;
    checks++;
    if (underflow !== 1'b1) begin failures++; $display("FAIL underflow_set got=%b exp=1", underflow); end
    checks++;
    if (inst_empty !== 1'b1) begin failures++; $display("FAIL underflow_empty got=%b exp=1", inst_empty); end
    go(12'h040, 16'd10);
    run(1'b1, 60);
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== W'(12'h040 + i)) bad++;
    checks++;
    if (bad != 0 || got_q.size() != 10) begin failures++; $display("FAIL tput_order mismatches=%0d pops=%0d exp=0/10", bad, got_q.size()); end
    checks++;
    if (pop_at.size() == 0 || pop_at[0] != 3) begin failures++; $display("FAIL tput_latency got=%0d exp=3", pop_at.size() ? pop_at[0] : -1); end
    span = pop_at.size() == 10 ? pop_at[9] - pop_at[0] : -1;
    checks++;
    if (span != 9) begin failures++; $display("FAIL tput_rate span=%0d exp=9", span); end
    checks++;
    if (underflow !== 1'b1) begin failures++; $display("FAIL underflow_sticky got=%b exp=1", underflow); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    go(12'h050, 16'd20);
    repeat (7) cyc(1'b0);
    checks++;
    if (inst_empty !== 1'b0 || imem_rd_en !== 1'b1) begin failures++; $display("FAIL rstmid_setup empty=%b rd_en=%b exp=0/1", inst_empty, imem_rd_en); end
    rst_n = 1'b0;
    @(negedge clk);
    checks += 4;
    if (inst_empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b exp=1", inst_empty); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    if (instruct !== '0) begin failures++; $display("FAIL rstmid_instruct got=%h exp=0", instruct); end
    if (underflow !== 1'b0) begin failures++; $display("FAIL rstmid_underflow got=%b exp=0", underflow); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (inst_empty !== 1'b1) begin failures++; $display("FAIL rstmid_late_push got=%b exp=1", inst_empty); end
    go(12'h060, 16'd2);
    run(1'b1, 30);
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== W'(12'h060 + i)) bad++;
    checks++;
    if (bad != 0 || got_q.size() != 2) begin failures++; $display("FAIL rstmid_rerun mismatches=%0d pops=%0d exp=0/2", bad, got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_and_busy();
    test_underflow_throughput();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
